// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// The stage holds one decoded instruction and forwards operands when it
// captures them, preferring the EX result, then the MEM value, then the
// register-file value. It stalls the decoder on a load-use dependency and
// counts the bubbles that this inserts.
module id_ex_stage #(
    parameter int REG_AW = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    // Decode side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [31:0]       in_rs1_data,
    input  logic [31:0]       in_rs2_data,
    input  logic [31:0]       in_imm,
    input  logic              in_alu_src_imm,
    input  logic [6:0]        in_alu_control,
    input  logic [1:0]        in_branch_control,
    input  logic              in_reg_write,
    input  logic              in_is_load,
    input  logic              flush,
    // Forwarding sources
    input  logic [31:0]       alu_result,
    input  logic              mem_fwd_valid,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [31:0]       mem_fwd_data,
    // Execute side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       SrcA,
    output logic [31:0]       SrcB,
    output logic [31:0]       store_data,
    output logic [6:0]        ALUControl,
    output logic [1:0]        BranchControl,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write,
    output logic              out_is_load,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_valid;
    logic [31:0]       r_src_a;
    logic [31:0]       r_src_b;
    logic [31:0]       r_store_data;
    logic [6:0]        r_alu_control;
    logic [1:0]        r_branch_control;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_reg_write;
    logic              r_is_load;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard;
    logic              w_ready;
    logic              w_xfer;
    logic              w_ex_fwd_en;
    logic [31:0]       w_rs1_fwd;
    logic [31:0]       w_rs2_fwd;

    // A held load whose result the incoming instruction reads cannot forward
    // yet (its data only exists in MEM), so the decoder must wait one cycle.
    assign w_hazard = r_valid && r_is_load && r_reg_write && (r_rd_addr != '0) &&
                      ((in_use_rs1 && (in_rs1_addr == r_rd_addr)) ||
                       (in_use_rs2 && (in_rs2_addr == r_rd_addr)));

    // Flush always accepts so that the wrong-path instruction is drained.
    assign w_ready  = flush || ((!r_valid || out_ready) && !w_hazard);
    assign w_xfer   = in_valid && w_ready && !flush;
    assign in_ready = w_ready;

    // The EX result is only forwardable when the held instruction is leaving
    // this cycle and it is an ALU write, not a load.
    assign w_ex_fwd_en = r_valid && out_ready && r_reg_write && !r_is_load;

    // Operand forwarding mux: EX beats MEM beats register file; x0 is never forwarded.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rs1_fwd = in_rs1_data;
        w_rs2_fwd = in_rs2_data;
        if (in_rs1_addr != '0) begin
            if (w_ex_fwd_en && (r_rd_addr == in_rs1_addr)) begin
                w_rs1_fwd = alu_result;
            end else if (mem_fwd_valid && (mem_fwd_rd == in_rs1_addr)) begin
                w_rs1_fwd = mem_fwd_data;
            end
        end
        if (in_rs2_addr != '0) begin
            if (w_ex_fwd_en && (r_rd_addr == in_rs2_addr)) begin
                w_rs2_fwd = alu_result;
            end else if (mem_fwd_valid && (mem_fwd_rd == in_rs2_addr)) begin
                w_rs2_fwd = mem_fwd_data;
            end
        end
    end

    // Valid flag: flush kills, a transfer fills, an accepted hand-off drains.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Instruction fields load only on transfer and otherwise keep their value.
    // NOTE: the datapath fields sit on the async reset because their outputs
    // must read as zero while reset is held, not just out_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_src_a          <= '0;
            r_src_b          <= '0;
            r_store_data     <= '0;
            r_alu_control    <= '0;
            r_branch_control <= '0;
            r_rd_addr        <= '0;
            r_reg_write      <= 1'b0;
            r_is_load        <= 1'b0;
        end else if (w_xfer) begin
            r_src_a          <= w_rs1_fwd;
            r_src_b          <= in_alu_src_imm ? in_imm : w_rs2_fwd;
            r_store_data     <= w_rs2_fwd;
            r_alu_control    <= in_alu_control;
            r_branch_control <= in_branch_control;
            r_rd_addr        <= in_rd_addr;
            r_reg_write      <= in_reg_write;
            r_is_load        <= in_is_load;
        end
    end

    // Saturating count of the load-use bubbles pushed downstream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bubble_cnt <= '0;
        end else if (w_hazard && in_valid && out_ready && !flush && !(&r_bubble_cnt)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign out_valid     = r_valid;
    assign SrcA          = r_src_a;
    assign SrcB          = r_src_b;
    assign store_data    = r_store_data;
    assign ALUControl    = r_alu_control;
    assign BranchControl = r_branch_control;
    assign out_rd_addr   = r_rd_addr;
    assign out_reg_write = r_reg_write;
    assign out_is_load   = r_is_load;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// multi-cycle sequences (stall, flush, load-use, counter saturation, async
// reset) and a randomized run against a behavioural model of the stage.
module tb_id_ex_stage;

    localparam int REG_AW = 6;
    // A narrow counter keeps the saturation sequence short.
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic              in_use_rs1, in_use_rs2;
    logic [31:0]       in_rs1_data, in_rs2_data, in_imm;
    logic              in_alu_src_imm;
    logic [6:0]        in_alu_control;
    logic [1:0]        in_branch_control;
    logic              in_reg_write, in_is_load, flush;
    logic [31:0]       alu_result;
    logic              mem_fwd_valid;
    logic [REG_AW-1:0] mem_fwd_rd;
    logic [31:0]       mem_fwd_data;
    logic              out_valid, out_ready;
    logic [31:0]       SrcA, SrcB, store_data;
    logic [6:0]        ALUControl;
    logic [1:0]        BranchControl;
    logic [REG_AW-1:0] out_rd_addr;
    logic              out_reg_write, out_is_load;
    logic [CNT_W-1:0]  bubble_cnt;

    id_ex_stage #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_alu_src_imm(in_alu_src_imm), .in_alu_control(in_alu_control),
        .in_branch_control(in_branch_control),
        .in_reg_write(in_reg_write), .in_is_load(in_is_load), .flush(flush),
        .alu_result(alu_result),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .store_data(store_data),
        .ALUControl(ALUControl), .BranchControl(BranchControl),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_is_load(out_is_load),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              valid;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic              u1, u2;
        logic [31:0]       d1, d2, imm;
        logic              srcimm;
        logic [6:0]        aluc;
        logic [1:0]        brc;
        logic              rw, ld, flush;
        logic [31:0]       alu;
        logic              mfv;
        logic [REG_AW-1:0] mrd;
        logic [31:0]       mdata;
        logic              oready;
    } in_t;

    typedef struct {
        string             name;
        logic              hold;
        logic [REG_AW-1:0] h_rd;
        logic              h_rw, h_ld;
        in_t               s;
        logic              e_ready, e_valid, chk;
        logic [31:0]       e_a, e_b, e_sd;
    } vec_t;

    // Behavioural view of the held instruction.
    typedef struct {
        logic              valid;
        logic [31:0]       a, b, sd;
        logic [6:0]        aluc;
        logic [1:0]        brc;
        logic [REG_AW-1:0] rd;
        logic              rw, ld;
        int                bubbles;
    } model_t;

    int     n_checks = 0;
    int     n_errors = 0;
    vec_t   vecs[11];
    model_t m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t s;
        s.valid = 1'b0; s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.u1 = 1'b0; s.u2 = 1'b0;
        s.d1 = '0; s.d2 = '0; s.imm = '0; s.srcimm = 1'b0; s.aluc = '0; s.brc = '0;
        s.rw = 1'b0; s.ld = 1'b0; s.flush = 1'b0; s.alu = '0; s.mfv = 1'b0;
        s.mrd = '0; s.mdata = '0; s.oready = 1'b0;
        return s;
    endfunction

    task automatic apply(input in_t s);
        in_valid = s.valid; in_rs1_addr = s.rs1; in_rs2_addr = s.rs2; in_rd_addr = s.rd;
        in_use_rs1 = s.u1; in_use_rs2 = s.u2; in_rs1_data = s.d1; in_rs2_data = s.d2;
        in_imm = s.imm; in_alu_src_imm = s.srcimm; in_alu_control = s.aluc;
        in_branch_control = s.brc; in_reg_write = s.rw; in_is_load = s.ld; flush = s.flush;
        alu_result = s.alu; mem_fwd_valid = s.mfv; mem_fwd_rd = s.mrd;
        mem_fwd_data = s.mdata; out_ready = s.oready;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input string name, input logic hold, input logic [REG_AW-1:0] h_rd,
                                 input logic h_rw, input logic h_ld,
                                 input logic [REG_AW-1:0] rs1, input logic u1, input logic [31:0] d1,
                                 input logic [REG_AW-1:0] rs2, input logic u2, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic srcimm, input logic [31:0] alu,
                                 input logic mfv, input logic [REG_AW-1:0] mrd, input logic [31:0] mdata,
                                 input logic oready, input logic e_ready, input logic e_valid,
                                 input logic chk, input logic [31:0] e_a, input logic [31:0] e_b,
                                 input logic [31:0] e_sd);
        vec_t v;
        v.name = name; v.hold = hold; v.h_rd = h_rd; v.h_rw = h_rw; v.h_ld = h_ld;
        v.s = idle();
        v.s.valid = 1'b1; v.s.rs1 = rs1; v.s.u1 = u1; v.s.d1 = d1;
        v.s.rs2 = rs2; v.s.u2 = u2; v.s.d2 = d2; v.s.imm = imm; v.s.srcimm = srcimm;
        v.s.rd = 6'd7; v.s.rw = 1'b1; v.s.alu = alu; v.s.mfv = mfv; v.s.mrd = mrd;
        v.s.mdata = mdata; v.s.oready = oready;
        v.e_ready = e_ready; v.e_valid = e_valid; v.chk = chk;
        v.e_a = e_a; v.e_b = e_b; v.e_sd = e_sd;
        return v;
    endfunction

    // Forwarded value of one source operand, following the priority rules.
    function automatic logic [31:0] model_fwd(input model_t mm, input in_t s,
                                              input logic [REG_AW-1:0] src, input logic [31:0] rf);
        if (src == 0) return rf;
        if (mm.valid && s.oready && mm.rw && !mm.ld && mm.rd == src) return s.alu;
        if (s.mfv && s.mrd == src) return s.mdata;
        return rf;
    endfunction

    function automatic logic model_hazard(input model_t mm, input in_t s);
        return mm.valid && mm.ld && mm.rw && (mm.rd != 0) &&
               ((s.u1 && s.rs1 == mm.rd) || (s.u2 && s.rs2 == mm.rd));
    endfunction

    task automatic check_model_outputs(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 64'(m.valid));
        check({tag, " bubble_cnt"}, 64'(bubble_cnt), 64'(m.bubbles));
        check({tag, " SrcA"}, 64'(SrcA), 64'(m.a));
        check({tag, " SrcB"}, 64'(SrcB), 64'(m.b));
        check({tag, " store_data"}, 64'(store_data), 64'(m.sd));
        check({tag, " ctrl"}, {out_rd_addr, ALUControl, BranchControl, out_reg_write, out_is_load},
                              {m.rd, m.aluc, m.brc, m.rw, m.ld});
    endtask

    task automatic do_reset();
        apply(idle());
        @(negedge clk);
        rstn = 1'b0;
        #3;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        check("reset data", {SrcA, SrcB}, 64'd0);
        check("reset store_data", 64'(store_data), 64'd0);
        check("reset ctrl", {out_rd_addr, ALUControl, BranchControl, out_reg_write, out_is_load}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    in_t s, ld_i, hz_i, x_i;

    initial begin
        rstn = 1'b1;
        apply(idle());
        #1 rstn = 1'b0;
        do_reset();

        // ---------------- directed vector table ----------------
        //              name                  hold rd rw ld  rs1 u1 d1       rs2 u2 d2       imm    si alu    mfv mrd mdata  ordy rdy vld chk A      B      SD
        vecs[0]  = mkv("first_capture",       0, 0, 0, 0,  1, 1, 32'h5,   2, 0, 32'h22,  32'h7,  1, 32'h0,  0, 0, 32'h0,  0,   1,  1,  1, 32'h5,  32'h7,  32'h22);
        vecs[1]  = mkv("ex_over_mem",         1, 3, 1, 0,  3, 1, 32'h1,   3, 1, 32'h2,   32'h44, 0, 32'h10, 1, 3, 32'h99, 1,   1,  1,  1, 32'h10, 32'h10, 32'h10);
        vecs[2]  = mkv("mem_fwd",             1, 5, 1, 0,  3, 1, 32'h1,   6, 1, 32'h2,   32'h0,  0, 32'h10, 1, 3, 32'h99, 1,   1,  1,  1, 32'h99, 32'h2,  32'h2);
        vecs[3]  = mkv("x0_never_fwd",        1, 0, 1, 0,  0, 1, 32'h0,   0, 1, 32'h0,   32'h0,  0, 32'h55, 1, 0, 32'hFF, 1,   1,  1,  1, 32'h0,  32'h0,  32'h0);
        vecs[4]  = mkv("stall_no_capture",    1, 3, 1, 0,  3, 1, 32'h1,   2, 1, 32'h2,   32'h0,  0, 32'h10, 0, 0, 32'h0,  0,   0,  1,  0, 32'h0,  32'h0,  32'h0);
        vecs[5]  = mkv("load_no_ex_fwd",      1, 3, 1, 1,  3, 0, 32'h31,  2, 0, 32'h32,  32'h0,  0, 32'h10, 0, 0, 32'h0,  1,   1,  1,  1, 32'h31, 32'h32, 32'h32);
        vecs[6]  = mkv("load_use_hazard",     1, 4, 1, 1,  1, 1, 32'h1,   4, 1, 32'h2,   32'h0,  0, 32'h0,  0, 0, 32'h0,  1,   0,  0,  0, 32'h0,  32'h0,  32'h0);
        vecs[7]  = mkv("load_rd0_no_hazard",  1, 0, 1, 1,  1, 1, 32'h3,   0, 1, 32'h0,   32'h0,  0, 32'h0,  0, 0, 32'h0,  1,   1,  1,  1, 32'h3,  32'h0,  32'h0);
        vecs[8]  = mkv("load_nowr_no_hazard", 1, 4, 0, 1,  1, 1, 32'h41,  4, 1, 32'h42,  32'h0,  0, 32'h10, 0, 0, 32'h0,  1,   1,  1,  1, 32'h41, 32'h42, 32'h42);
        vecs[9]  = mkv("imm_with_ex_rs2",     1, 3, 1, 0,  1, 1, 32'h5,   3, 1, 32'h6,   32'h77, 1, 32'h10, 0, 0, 32'h0,  1,   1,  1,  1, 32'h5,  32'h77, 32'h10);
        vecs[10] = mkv("ex_needs_reg_write",  1, 3, 0, 0,  3, 1, 32'h1,   2, 1, 32'h2,   32'h0,  0, 32'h10, 1, 3, 32'h99, 1,   1,  1,  1, 32'h99, 32'h2,  32'h2);

        for (int i = 0; i < 11; i++) begin
            s = idle();
            s.flush = 1'b1;
            apply(s);
            step();
            if (vecs[i].hold) begin
                s = idle();
                s.valid = 1'b1; s.rd = vecs[i].h_rd; s.rw = vecs[i].h_rw; s.ld = vecs[i].h_ld;
                apply(s);
                step();
            end
            apply(vecs[i].s);
            #1;
            check({vecs[i].name, " in_ready"}, 64'(in_ready), 64'(vecs[i].e_ready));
            step();
            check({vecs[i].name, " out_valid"}, 64'(out_valid), 64'(vecs[i].e_valid));
            if (vecs[i].chk) begin
                check({vecs[i].name, " SrcA"}, 64'(SrcA), 64'(vecs[i].e_a));
                check({vecs[i].name, " SrcB"}, 64'(SrcB), 64'(vecs[i].e_b));
                check({vecs[i].name, " store_data"}, 64'(store_data), 64'(vecs[i].e_sd));
            end
        end

        // ---------------- stall for 3 cycles, then flush under stall ----------------
        s = idle(); s.flush = 1'b1; apply(s); step();
        x_i = idle();
        x_i.valid = 1'b1; x_i.rs1 = 1; x_i.d1 = 32'h111; x_i.rs2 = 2; x_i.d2 = 32'h222;
        x_i.imm = 32'h333; x_i.aluc = 7'h2A; x_i.brc = 2'd2; x_i.rd = 9; x_i.rw = 1'b1;
        apply(x_i); step();
        s = idle();
        s.valid = 1'b1; s.rs1 = 5; s.d1 = 32'hAAA; s.rs2 = 6; s.d2 = 32'hBBB; s.imm = 32'hCCC;
        s.aluc = 7'h01; s.brc = 2'd1; s.rd = 12; s.ld = 1'b1; s.oready = 1'b0;
        apply(s);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall in_ready", 64'(in_ready), 64'd0);
            step();
            check("stall out_valid", 64'(out_valid), 64'd1);
            check("stall data", {SrcA, SrcB}, {32'h111, 32'h222});
            check("stall store_data", 64'(store_data), 64'h222);
            check("stall ctrl", {out_rd_addr, ALUControl, BranchControl, out_reg_write, out_is_load},
                                {6'd9, 7'h2A, 2'd2, 1'b1, 1'b0});
        end
        s.flush = 1'b1;
        apply(s);
        #1;
        check("flush in_ready", 64'(in_ready), 64'd1);
        step();
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush keeps fields", {SrcA, SrcB}, {32'h111, 32'h222});

        // ---------------- load-use bubble, then capture with MEM forward ----------------
        do_reset();
        ld_i = idle();
        ld_i.valid = 1'b1; ld_i.rd = 4; ld_i.rw = 1'b1; ld_i.ld = 1'b1; ld_i.oready = 1'b1;
        apply(ld_i); step();
        hz_i = idle();
        hz_i.valid = 1'b1; hz_i.rs1 = 1; hz_i.u1 = 1'b1; hz_i.d1 = 32'h7;
        hz_i.rs2 = 4; hz_i.u2 = 1'b1; hz_i.d2 = 32'h5; hz_i.oready = 1'b1;
        apply(hz_i);
        #1;
        check("loaduse in_ready", 64'(in_ready), 64'd0);
        step();
        check("loaduse out_valid", 64'(out_valid), 64'd0);
        check("loaduse bubble_cnt", 64'(bubble_cnt), 64'd1);
        s = hz_i; s.mfv = 1'b1; s.mrd = 4; s.mdata = 32'hAB;
        apply(s);
        #1;
        check("loaduse retry in_ready", 64'(in_ready), 64'd1);
        step();
        check("loaduse retry out_valid", 64'(out_valid), 64'd1);
        check("loaduse retry store_data", 64'(store_data), 64'hAB);
        check("loaduse retry SrcA", 64'(SrcA), 64'h7);

        // ---------------- bubble counter saturation ----------------
        for (int k = 0; k < int'(CNT_MAX) - 1; k++) begin
            apply(ld_i); step();
            apply(hz_i); step();
        end
        check("bubble reaches max", 64'(bubble_cnt), 64'(CNT_MAX));
        apply(ld_i); step();
        apply(hz_i);
        #1;
        check("saturate in_ready", 64'(in_ready), 64'd0);
        step();
        check("bubble saturates", 64'(bubble_cnt), 64'(CNT_MAX));

        // ---------------- async reset mid-cycle ----------------
        apply(ld_i); step();
        check("pre-reset out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        check("async reset ctrl", {out_rd_addr, out_reg_write, out_is_load}, 64'd0);
        apply(idle());
        @(negedge clk);
        rstn = 1'b1;

        // ---------------- randomized run against the model ----------------
        do_reset();
        m.valid = 1'b0; m.a = '0; m.b = '0; m.sd = '0; m.aluc = '0; m.brc = '0;
        m.rd = '0; m.rw = 1'b0; m.ld = 1'b0; m.bubbles = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        hz, rdy;
            logic [31:0] f1, f2;
            s = idle();
            s.valid  = ($urandom_range(0, 3) != 0);
            s.rs1    = REG_AW'($urandom_range(0, 3));
            s.rs2    = REG_AW'($urandom_range(0, 3));
            s.rd     = REG_AW'($urandom_range(0, 3));
            s.u1     = $urandom_range(0, 1) == 1;
            s.u2     = $urandom_range(0, 1) == 1;
            s.d1     = $urandom;
            s.d2     = $urandom;
            s.imm    = $urandom;
            s.srcimm = $urandom_range(0, 1) == 1;
            s.aluc   = 7'($urandom);
            s.brc    = 2'($urandom);
            s.rw     = $urandom_range(0, 3) != 0;
            s.ld     = $urandom_range(0, 2) == 0;
            s.flush  = $urandom_range(0, 15) == 0;
            s.alu    = $urandom;
            s.mfv    = $urandom_range(0, 1) == 1;
            s.mrd    = REG_AW'($urandom_range(0, 3));
            s.mdata  = $urandom;
            s.oready = $urandom_range(0, 2) != 0;
            apply(s);

            hz  = model_hazard(m, s);
            rdy = s.flush || ((!m.valid || s.oready) && !hz);
            f1  = model_fwd(m, s, s.rs1, s.d1);
            f2  = model_fwd(m, s, s.rs2, s.d2);
            #1;
            check("rand in_ready", 64'(in_ready), 64'(rdy));

            if (hz && s.valid && s.oready && !s.flush && m.bubbles < int'(CNT_MAX))
                m.bubbles++;
            if (s.flush) begin
                m.valid = 1'b0;
            end else if (s.valid && rdy) begin
                m.valid = 1'b1;
                m.a = f1; m.b = s.srcimm ? s.imm : f2; m.sd = f2;
                m.aluc = s.aluc; m.brc = s.brc; m.rd = s.rd; m.rw = s.rw; m.ld = s.ld;
            end else if (s.oready) begin
                m.valid = 1'b0;
            end
            step();
            check_model_outputs("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
